// File: rtl/btb_pkg.sv
// ============================================================================
// btb_pkg : shared widths, entry layout and tag extraction for the BTB
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package btb_pkg;
  localparam int WORD_SIZE          = 16;
  localparam int DEFAULT_ENTRY_BITS = 8;
  localparam int TAG_LSB            = DEFAULT_ENTRY_BITS;

  // Tag is kept right-aligned at full word width so any ENTRY_BITS fits.
  typedef struct packed {
    logic                 valid;
    logic [WORD_SIZE-1:0] tag;
    logic [WORD_SIZE-1:0] target;
  } btb_entry_t;

  function automatic logic [WORD_SIZE-1:0] pc_tag(input logic [WORD_SIZE-1:0] pc,
                                                  input int entry_bits);
    return pc >> entry_bits;
  endfunction
endpackage

`default_nettype wire

// File: rtl/sat_counter16.sv
// ============================================================================
// sat_counter16 : 16-bit event counter that holds at 0xFFFF
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module sat_counter16 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  output logic [15:0] count
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 16'h0000;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end
endmodule

`default_nettype wire

// File: rtl/branch_target_buffer.sv
// ============================================================================
// branch_target_buffer : direct-mapped BTB, combinational lookup, 1-cycle write
// Optional perf counters built when BTB_PERF_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int WORD_SIZE  = btb_pkg::WORD_SIZE,
  parameter int ENTRY_BITS = DEFAULT_ENTRY_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] IF_pc,
  input  logic                 lookup_valid,
  output logic [WORD_SIZE-1:0] predicted_pc,
  output logic                 btb_hit,
  input  logic                 BtbWrite,
  input  logic [WORD_SIZE-1:0] ID_pc,
  input  logic [WORD_SIZE-1:0] correct_address,
  input  logic                 ID_stall,
  output logic [15:0]          perf_lookups,
  output logic [15:0]          perf_hits,
  output logic [15:0]          perf_writes
);
  localparam int ENTRIES = 1 << ENTRY_BITS;

  logic [ENTRIES-1:0]    valid_q;
  logic [WORD_SIZE-1:0]  tag_mem    [ENTRIES];
  logic [WORD_SIZE-1:0]  target_mem [ENTRIES];
  logic [ENTRY_BITS-1:0] rd_idx;
  logic [ENTRY_BITS-1:0] wr_idx;
  logic                  write_accept;
  btb_entry_t            rd_entry;

  assign rd_idx = IF_pc[ENTRY_BITS-1:0];
  assign wr_idx = ID_pc[ENTRY_BITS-1:0];

  // Identity compare so an unknown BtbWrite never opens the write port.
  assign write_accept = (BtbWrite === 1'b1) && (ID_stall == 1'b0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (write_accept) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (write_accept && reset_n) begin
      tag_mem[wr_idx]    <= pc_tag(ID_pc, ENTRY_BITS);
      target_mem[wr_idx] <= correct_address;
    end
  end

  assign rd_entry     = '{valid: valid_q[rd_idx], tag: tag_mem[rd_idx], target: target_mem[rd_idx]};
  assign btb_hit      = rd_entry.valid && (rd_entry.tag == pc_tag(IF_pc, ENTRY_BITS));
  assign predicted_pc = btb_hit ? rd_entry.target : IF_pc + WORD_SIZE'(1);

`ifdef BTB_PERF_EN
  sat_counter16 u_perf_lookups (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (lookup_valid),
    .count   (perf_lookups)
  );
  sat_counter16 u_perf_hits (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (lookup_valid && btb_hit),
    .count   (perf_hits)
  );
  sat_counter16 u_perf_writes (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (write_accept),
    .count   (perf_writes)
  );
`else
  logic unused_perf;
  assign unused_perf  = lookup_valid;
  assign perf_lookups = 16'h0000;
  assign perf_hits    = 16'h0000;
  assign perf_writes  = 16'h0000;
`endif
endmodule

`default_nettype wire
